// File: rtl/ippcrc_crc32_stream.sv
// Streaming reflected CRC-32 engine (poly 0x04C11DB7, Ethernet convention).
// Accumulates CRC over sop/eop-delimited packets of DW-bit words, finishes a
// partial last word one byte per cycle, and reports CRC, length and residue check.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   i_vld/o_rdy            input handshake, transfer on i_vld & o_rdy
//   i_sop/i_eop/i_nbyte    packet framing; i_nbyte = valid bytes on eop (0 = all)
//   i_data                 lane 0 = i_data[7:0] first on the wire
//   o_vld                  one-cycle result strobe
//   o_crc/o_crc_ok/o_len   final CRC, residue pass, byte count (held until next o_vld)
//   o_sop_err/o_eop_err    one-cycle framing error pulses
module ippcrc_crc32_stream #(
  parameter int unsigned DW         = 64,
  parameter logic [31:0] CRC_INIT   = 32'hFFFFFFFF,
  parameter logic [31:0] CRC_XOROUT = 32'hFFFFFFFF,
  parameter logic [31:0] CRC_RES    = 32'hDEBB20E3,
  parameter int unsigned CHK_EN     = 1,
  localparam int unsigned NB        = DW / 8,
  localparam int unsigned NBW       = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_vld,
  output logic           o_rdy,
  input  logic           i_sop,
  input  logic           i_eop,
  input  logic [NBW-1:0] i_nbyte,
  input  logic [DW-1:0]  i_data,
  output logic           o_vld,
  output logic [31:0]    o_crc,
  output logic           o_crc_ok,
  output logic [15:0]    o_len,
  output logic           o_sop_err,
  output logic           o_eop_err
);

  localparam logic [31:0] POLY_REF = 32'hEDB88320;

  typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_TAIL} state_t;

  state_t         state_q, state_d;
  logic [31:0]    crc_q, crc_d;
  logic [15:0]    len_q, len_d;
  logic [DW-1:0]  tail_q, tail_d;
  logic [NBW-1:0] cnt_q, cnt_d;

  logic           fin;
  logic [31:0]    fin_raw;
  logic [15:0]    fin_len;
  logic           sop_err_d, eop_err_d;
  logic [31:0]    base_crc;
  logic [15:0]    base_len;

  // One byte through the reflected LFSR, bit 0 first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r >> 1) ^ (((r[0] ^ b[i]) != 1'b0) ? POLY_REF : 32'h0);
    end
    return r;
  endfunction

  // Whole word, lane 0 first.
  function automatic logic [31:0] crc_word(input logic [31:0] c, input logic [DW-1:0] d);
    logic [31:0] r;
    r = c;
    for (int l = 0; l < int'(NB); l++) begin
      r = crc_byte(r, d[8*l +: 8]);
    end
    return r;
  endfunction

  // Saturating length add.
  function automatic logic [15:0] len_add(input logic [15:0] l, input logic [15:0] inc);
    logic [16:0] s;
    s = {1'b0, l} + {1'b0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Next-state and datapath.
  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    len_d     = len_q;
    tail_d    = tail_q;
    cnt_d     = cnt_q;
    fin       = 1'b0;
    fin_raw   = crc_q;
    fin_len   = len_q;
    sop_err_d = 1'b0;
    eop_err_d = 1'b0;
    base_crc  = CRC_INIT;
    base_len  = 16'h0;
    case (state_q)
      ST_IDLE, ST_ACC: begin
        if (i_vld) begin
          if ((state_q == ST_IDLE) && !i_sop) begin
            eop_err_d = 1'b1;
          end else begin
            sop_err_d = (state_q == ST_ACC) && i_sop;
            base_crc  = i_sop ? CRC_INIT : crc_q;
            base_len  = i_sop ? 16'h0 : len_q;
            if (i_eop && (NB > 1) && (i_nbyte != '0)) begin
              // Partial last word: drain byte by byte from the tail register.
              tail_d  = i_data;
              cnt_d   = i_nbyte;
              crc_d   = base_crc;
              len_d   = len_add(base_len, 16'(i_nbyte));
              state_d = ST_TAIL;
            end else begin
              crc_d = crc_word(base_crc, i_data);
              len_d = len_add(base_len, 16'(NB));
              if (i_eop) begin
                fin     = 1'b1;
                fin_raw = crc_d;
                fin_len = len_d;
                crc_d   = CRC_INIT;
                len_d   = 16'h0;
                state_d = ST_IDLE;
              end else begin
                state_d = ST_ACC;
              end
            end
          end
        end
      end
      ST_TAIL: begin
        crc_d  = crc_byte(crc_q, tail_q[7:0]);
        tail_d = tail_q >> 8;
        cnt_d  = cnt_q - NBW'(1);
        if (cnt_q == NBW'(1)) begin
          fin     = 1'b1;
          fin_raw = crc_d;
          fin_len = len_q;
          crc_d   = CRC_INIT;
          len_d   = 16'h0;
          tail_d  = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      crc_q     <= CRC_INIT;
      len_q     <= 16'h0;
      tail_q    <= '0;
      cnt_q     <= '0;
      o_rdy     <= 1'b1;
      o_vld     <= 1'b0;
      o_crc     <= 32'h0;
      o_crc_ok  <= 1'b0;
      o_len     <= 16'h0;
      o_sop_err <= 1'b0;
      o_eop_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      len_q     <= len_d;
      tail_q    <= tail_d;
      cnt_q     <= cnt_d;
      o_rdy     <= (state_d != ST_TAIL);
      o_vld     <= fin;
      o_sop_err <= sop_err_d;
      o_eop_err <= eop_err_d;
      if (fin) begin
        o_crc    <= fin_raw ^ CRC_XOROUT;
        o_crc_ok <= (CHK_EN != 0) && (fin_raw == CRC_RES);
        o_len    <= fin_len;
      end
    end
  end

endmodule

// File: tb/tb_ippcrc_crc32_stream.sv
// Directed bench for ippcrc_crc32_stream (DW=64) with hand-computed CRC vectors.
module tb_ippcrc_crc32_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_vld = 1'b0;
  logic        i_sop = 1'b0;
  logic        i_eop = 1'b0;
  logic [2:0]  i_nbyte = 3'd0;
  logic [63:0] i_data = 64'h0;
  logic        o_rdy, o_vld, o_crc_ok, o_sop_err, o_eop_err;
  logic [31:0] o_crc;
  logic [15:0] o_len;

  localparam logic [63:0] W_1TO8 = 64'h3837363534333231; // "12345678"
  localparam logic [63:0] W_9    = 64'hA5A5A5A5A5A5A539; // "9", pad lanes junk
  localparam logic [31:0] CRC_CHK  = 32'hCBF43926;
  localparam logic [31:0] CRC_Z8   = 32'h6522DF69;
  localparam logic [31:0] CRC_GOOD = 32'h2144DF1C;

  ippcrc_crc32_stream #(.DW(64)) dut (
    .clk(clk), .rst_n(rst_n), .i_vld(i_vld), .o_rdy(o_rdy), .i_sop(i_sop),
    .i_eop(i_eop), .i_nbyte(i_nbyte), .i_data(i_data), .o_vld(o_vld),
    .o_crc(o_crc), .o_crc_ok(o_crc_ok), .o_len(o_len),
    .o_sop_err(o_sop_err), .o_eop_err(o_eop_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int last_acc = 0;
  int vld_cnt = 0, sop_err_cnt = 0, eop_err_cnt = 0, rdy_low_cnt = 0;

  typedef struct {
    logic [31:0] crc;
    logic        ok;
    logic [15:0] len;
    int          c;
  } res_t;
  res_t resq[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Result/strobe monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (o_vld) begin
      resq.push_back('{o_crc, o_crc_ok, o_len, cyc});
      vld_cnt++;
    end
    if (o_sop_err) sop_err_cnt++;
    if (o_eop_err) eop_err_cnt++;
    if (!o_rdy) rdy_low_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one word and hold it until accepted; returns at the negedge after acceptance.
  task automatic xfer(input logic s, input logic e, input logic [2:0] nb, input logic [63:0] d);
    int n = 0;
    i_vld = 1'b1; i_sop = s; i_eop = e; i_nbyte = nb; i_data = d;
    while (!o_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("xfer_rdy_timeout", 64'(o_rdy), 64'd1);
    @(posedge clk);
    @(negedge clk);
    last_acc = cyc;
    i_vld = 1'b0; i_sop = 1'b0; i_eop = 1'b0; i_nbyte = 3'd0; i_data = 64'h0;
  endtask

  task automatic expect_res(input string tag, input logic do_crc, input logic do_ok,
                            input logic [31:0] crc, input logic ok, input logic [15:0] len,
                            input int acc, input int lat);
    res_t r;
    int n = 0;
    #1;
    while (resq.size() == 0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (resq.size() == 0) begin
      chk({tag, "_vld_timeout"}, 64'(resq.size()), 64'd1);
      return;
    end
    r = resq.pop_front();
    chk({tag, "_lat"}, 64'(r.c - acc + 1), 64'(lat));
    if (do_crc) chk({tag, "_crc"}, 64'(r.crc), 64'(crc));
    if (do_ok)  chk({tag, "_ok"}, 64'(r.ok), 64'(ok));
    chk({tag, "_len"}, 64'(r.len), 64'(len));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a0, a1, a2, r0, e0, s0, v0;

    // Reset values
    #12;
    chk("rst_vld", 64'(o_vld), 64'd0);
    chk("rst_crc", 64'(o_crc), 64'd0);
    chk("rst_ok", 64'(o_crc_ok), 64'd0);
    chk("rst_len", 64'(o_len), 64'd0);
    chk("rst_sop_err", 64'(o_sop_err), 64'd0);
    chk("rst_eop_err", 64'(o_eop_err), 64'd0);
    chk("rst_rdy", 64'(o_rdy), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // "123456789": 8-byte word then 1-byte tail
    r0 = rdy_low_cnt;
    xfer(1'b1, 1'b0, 3'd5, W_1TO8);
    xfer(1'b0, 1'b1, 3'd1, W_9);
    a0 = last_acc;
    expect_res("t1", 1'b1, 1'b1, CRC_CHK, 1'b0, 16'd9, a0, 2);
    chk("t1_rdy_low", 64'(rdy_low_cnt - r0), 64'd1);

    // Same plus FCS 26 39 F4 CB: good residue
    xfer(1'b1, 1'b0, 3'd0, W_1TO8);
    xfer(1'b0, 1'b1, 3'd5, 64'h000000CBF4392639);
    a0 = last_acc;
    expect_res("t2", 1'b1, 1'b1, CRC_GOOD, 1'b1, 16'd13, a0, 6);

    // One data bit flipped: residue fails
    xfer(1'b1, 1'b0, 3'd0, 64'h3837363534333230);
    xfer(1'b0, 1'b1, 3'd5, 64'h000000CBF4392639);
    a0 = last_acc;
    expect_res("t2flip", 1'b0, 1'b1, 32'h0, 1'b0, 16'd13, a0, 6);

    // Single-word packet of zeros, back-to-back sop
    xfer(1'b1, 1'b1, 3'd0, 64'h0);
    a0 = last_acc;
    xfer(1'b1, 1'b0, 3'd0, W_1TO8);
    a1 = last_acc;
    chk("t3_b2b_accept", 64'(a1 - a0), 64'd1);
    xfer(1'b0, 1'b1, 3'd1, W_9);
    a2 = last_acc;
    expect_res("t3_zero", 1'b1, 1'b1, CRC_Z8, 1'b0, 16'd8, a0, 1);
    expect_res("t3_next", 1'b1, 1'b1, CRC_CHK, 1'b0, 16'd9, a2, 2);

    // Word without sop in IDLE
    e0 = eop_err_cnt;
    v0 = vld_cnt;
    xfer(1'b0, 1'b0, 3'd0, W_1TO8);
    @(negedge clk);
    #1;
    chk("t4_eop_err", 64'(eop_err_cnt - e0), 64'd1);
    chk("t4_no_vld", 64'(vld_cnt - v0), 64'd0);

    // sop inside a packet restarts it
    s0 = sop_err_cnt;
    xfer(1'b1, 1'b0, 3'd0, 64'h0123456789ABCDEF);
    xfer(1'b1, 1'b0, 3'd0, W_1TO8);
    xfer(1'b0, 1'b1, 3'd1, W_9);
    a0 = last_acc;
    expect_res("t4_restart", 1'b1, 1'b1, CRC_CHK, 1'b0, 16'd9, a0, 2);
    chk("t4_sop_err", 64'(sop_err_cnt - s0), 64'd1);

    // Word held during TAIL is consumed only after it
    xfer(1'b1, 1'b0, 3'd0, W_1TO8);
    xfer(1'b0, 1'b1, 3'd1, W_9);
    a1 = last_acc;
    xfer(1'b1, 1'b1, 3'd0, 64'h0);
    a2 = last_acc;
    chk("t5_hold", 64'(a2 - a1), 64'd2);
    expect_res("t5_first", 1'b1, 1'b1, CRC_CHK, 1'b0, 16'd9, a1, 2);
    expect_res("t5_second", 1'b1, 1'b1, CRC_Z8, 1'b0, 16'd8, a2, 1);

    // Reset in 2nd cycle of a 7-byte tail
    xfer(1'b1, 1'b0, 3'd0, W_1TO8);
    xfer(1'b0, 1'b1, 3'd7, 64'h00FFEEDDCCBBAA99);
    @(negedge clk);
    v0 = vld_cnt;
    rst_n = 1'b0;
    #1;
    chk("t6_vld", 64'(o_vld), 64'd0);
    chk("t6_crc", 64'(o_crc), 64'd0);
    chk("t6_len", 64'(o_len), 64'd0);
    chk("t6_ok", 64'(o_crc_ok), 64'd0);
    chk("t6_rdy", 64'(o_rdy), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("t6_no_vld", 64'(vld_cnt - v0), 64'd0);
    xfer(1'b1, 1'b0, 3'd0, W_1TO8);
    xfer(1'b0, 1'b1, 3'd1, W_9);
    a0 = last_acc;
    expect_res("t6_after", 1'b1, 1'b1, CRC_CHK, 1'b0, 16'd9, a0, 2);

    // Length saturation: 8193 full words = 65544 bytes
    xfer(1'b1, 1'b0, 3'd0, 64'h0);
    for (int i = 0; i < 8191; i++) xfer(1'b0, 1'b0, 3'd0, 64'(i));
    xfer(1'b0, 1'b1, 3'd0, 64'h0);
    a0 = last_acc;
    expect_res("t7_sat", 1'b0, 1'b0, 32'h0, 1'b0, 16'hFFFF, a0, 1);

    repeat (4) @(negedge clk);
    #1;
    chk("q_empty", 64'(resq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ippcrc_crc32_stream.md
Name: ippcrc_crc32_stream

Overview:
- Streaming, parametrised CRC-32 engine. Polynomial 0x04C11DB7, reflected, Ethernet/IEEE 802.3 convention.
- Accumulates CRC over a packet of DW-bit words delimited by sop/eop, handles a partial last word, and reports the final CRC, the packet length, and (check mode) an FCS-residue pass/fail.
- Sits in the ippcrc package between a MAC-side word stream and the framer/deframer. It replaces per-width combinational CRC cores and their hand-built packet control.

Parameters:
- DW, 64, data width in bits; multiple of 8, range 8..256. NB = DW/8 byte lanes; NBW = max(1, clog2(NB)).
- CRC_INIT, 32'hFFFFFFFF, register value loaded at sop.
- CRC_XOROUT, 32'hFFFFFFFF, XOR applied to the register to form o_crc.
- CRC_RES, 32'hDEBB20E3, raw-register residue meaning a good FCS.
- CHK_EN, 1, 1 = drive o_crc_ok from the residue compare; 0 = o_crc_ok tied 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_vld  in  1  input word valid.
- o_rdy  out  1  engine can accept a word; transfer happens when i_vld & o_rdy.
- i_sop  in  1  first word of packet.
- i_eop  in  1  last word of packet.
- i_nbyte  in  NBW  valid bytes on an eop word, lanes 0..i_nbyte-1; 0 means all NB. Ignored when i_eop=0.
- i_data  in  DW  data; lane 0 = i_data[7:0] goes first on the wire, bit 0 of each lane first.
- o_vld  out  1  one-cycle result strobe.
- o_crc  out  32  final CRC (raw register ^ CRC_XOROUT), reflected; byte 0 on wire = o_crc[7:0].
- o_crc_ok  out  1  raw register == CRC_RES; valid with o_vld.
- o_len  out  16  packet byte count, saturating at 16'hFFFF; valid with o_vld.
- o_sop_err  out  1  one-cycle pulse: sop received inside a packet.
- o_eop_err  out  1  one-cycle pulse: word received outside a packet without sop.

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE, CRC register = CRC_INIT, length counter 0, tail register 0. Outputs after reset: o_vld=0, o_crc=0, o_crc_ok=0, o_len=0, o_sop_err=0, o_eop_err=0, o_rdy=1.
- Register update is reflected (LSB-first, shift-right form, poly 0xEDB88320 reflected). The full-word update is one combinational DW-bit step; the tail update is one 8-bit step.
- IDLE: o_rdy=1.
  - sop, no eop: load CRC_INIT then apply the word; len = NB; go to ACC.
  - sop & eop: single-word packet; handled as the eop cases below, starting from CRC_INIT.
  - No sop: word dropped, o_eop_err pulses next cycle, stay IDLE.
- ACC: o_rdy=1.
  - Word without eop: update CRC, len += NB.
  - sop: restart from CRC_INIT with this word, o_sop_err pulses, previous packet discarded with no o_vld.
- eop with i_nbyte==0 (full word), accepted in cycle T: update CRC and len. At T+1: o_vld=1, outputs registered, state IDLE. A new sop is accepted at T+1.
- eop with k = i_nbyte, 1..NB-1, accepted in cycle T:
  - The word is captured into the tail register; len += k; state TAIL.
  - TAIL spans T+1..T+k and processes one byte per cycle in lane order. o_rdy=0 throughout TAIL; i_vld words are held, not consumed.
  - At T+k+1: o_vld=1, state IDLE, o_rdy=1.
- o_crc, o_crc_ok, o_len hold their value until the next o_vld. o_vld, o_sop_err, o_eop_err are single-cycle pulses.
- No output backpressure: o_vld cannot be stalled.
- Length saturates at 16'hFFFF and does not wrap.
- Reset asserted mid-ACC or mid-TAIL: packet abandoned; no o_vld is produced.

Test Plan:
- DW=64, bytes "12345678" (sop) then "9" (eop, i_nbyte=1) -> o_vld exactly 2 cycles after eop accept, o_crc=32'hCBF43926, o_len=9, o_rdy low for 1 cycle.
- Same 9 bytes plus FCS bytes 26 39 F4 CB (eop word of 5 bytes) -> o_crc_ok=1, o_len=13, o_vld 6 cycles after eop. Flip any single data bit -> o_crc_ok=0.
- Single-word packet, sop&eop, i_nbyte=0, 8 bytes 0x00 -> o_vld next cycle, o_crc=32'h6522DF69, o_len=8. A back-to-back sop in the following cycle is accepted.
- Word with i_vld=1 and no sop in IDLE -> o_eop_err pulse, no o_vld. A sop during ACC -> o_sop_err pulse, and the result equals the CRC of the restarted packet only.
- i_vld held high during TAIL -> that word is not consumed until o_rdy=1; data ordering is preserved.
- rst_n pulled low in the 2nd TAIL cycle of a 7-byte tail -> all outputs 0 immediately, no o_vld; the next packet's CRC is correct.
